// File: rtl/aes_dec_key_ctrl.sv
// Round-key memory sequencer for the AES inverse cipher: writes expanded keys
// at ascending indices, then replays them Nr..0 to the decipher datapath.
module aes_dec_key_ctrl #(
    parameter int unsigned MAX_ROUND = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keygen_start,
    input  logic [1:0] key_size,
    input  logic       rk_valid,
    output logic       rk_ready,
    input  logic       dec_start,
    output logic       dec_key_valid,
    input  logic       dec_key_ready,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic [3:0] mem_round,
    output logic       keys_loaded,
    output logic       busy,
    output logic       dec_done,
    output logic       cfg_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        READY   = 3'd2,
        FETCH   = 3'd3,
        PRESENT = 3'd4
    } state_t;

    localparam logic [3:0] MAX_IDX = 4'(MAX_ROUND);

    state_t     state_q, state_d;
    logic [3:0] nr_q, nr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       keys_loaded_q, keys_loaded_d;
    logic       dec_done_q, dec_done_d;
    logic       cfg_err_q, cfg_err_d;

    // Handshakes: a transfer happens in any cycle where valid and ready are both
    // high; valid never waits for ready, and the presented data stays stable
    // from the first valid cycle until the transfer cycle.
    assign rk_ready      = (state_q == LOAD);
    assign mem_wr        = rk_ready & rk_valid & (cnt_q <= MAX_IDX);
    assign mem_rd        = (state_q == FETCH);
    assign dec_key_valid = (state_q == PRESENT);
    assign busy          = (state_q == LOAD) | (state_q == FETCH) | (state_q == PRESENT);
    assign mem_round     = cnt_q;
    assign keys_loaded   = keys_loaded_q;
    assign dec_done      = dec_done_q;
    assign cfg_err       = cfg_err_q;
    assign dbg_state     = state_q;

    always_comb begin
        state_d       = state_q;
        nr_d          = nr_q;
        cnt_d         = cnt_q;
        keys_loaded_d = keys_loaded_q;
        dec_done_d    = 1'b0;
        cfg_err_d     = 1'b0;
        case (state_q)
            IDLE, READY: begin
                // A reload request pre-empts a simultaneous decrypt request.
                if (keygen_start) begin
                    if (!key_size[1]) begin
                        nr_d          = key_size[0] ? 4'd12 : 4'd10;
                        cnt_d         = 4'd0;
                        keys_loaded_d = 1'b0;
                        state_d       = LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (state_q == READY && dec_start) begin
                    cnt_d   = nr_q;
                    state_d = FETCH;
                end
            end
            LOAD: begin
                if (mem_wr) begin
                    if (cnt_q == nr_q) begin
                        keys_loaded_d = 1'b1;
                        state_d       = READY;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            FETCH: state_d = PRESENT;
            PRESENT: begin
                // mem_rd is low here, so the memory output holds while stalled.
                if (dec_key_ready) begin
                    if (cnt_q == 4'd0) begin
                        dec_done_d = 1'b1;
                        state_d    = READY;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            nr_q          <= 4'd0;
            cnt_q         <= 4'd0;
            keys_loaded_q <= 1'b0;
            dec_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            nr_q          <= nr_d;
            cnt_q         <= cnt_d;
            keys_loaded_q <= keys_loaded_d;
            dec_done_q    <= dec_done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_aes_dec_key_ctrl.sv
// Bench for aes_dec_key_ctrl: directed load/decrypt scenarios with a cycle-stamped
// event scoreboard plus direct checks of stall, collision and reset behaviour.
module tb_aes_dec_key_ctrl;

    localparam int W = 23;
    localparam logic [2:0] K_WR   = 3'd1;
    localparam logic [2:0] K_RD   = 3'd2;
    localparam logic [2:0] K_ACC  = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;
    localparam logic [2:0] K_CFG  = 3'd5;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       keygen_start = 1'b0;
    logic [1:0] key_size = 2'd0;
    logic       rk_valid = 1'b0;
    logic       rk_ready;
    logic       dec_start = 1'b0;
    logic       dec_key_valid;
    logic       dec_key_ready = 1'b0;
    logic       mem_wr;
    logic       mem_rd;
    logic [3:0] mem_round;
    logic       keys_loaded;
    logic       busy;
    logic       dec_done;
    logic       cfg_err;
    logic [2:0] dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    aes_dec_key_ctrl #(.MAX_ROUND(13)) dut (
        .clk(clk), .rst_n(rst_n), .keygen_start(keygen_start), .key_size(key_size),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .dec_start(dec_start),
        .dec_key_valid(dec_key_valid), .dec_key_ready(dec_key_ready),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_round(mem_round),
        .keys_loaded(keys_loaded), .busy(busy), .dec_done(dec_done),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    // Clock and cycle index: between rising edges k and k+1, cyc == k.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [2:0] kind, input int rnd, input int cy);
        exp_q.push_back({kind, 4'(rnd), 16'(cy)});
    endtask

    task automatic observe(input logic [2:0] kind, input logic [3:0] rnd);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {kind, rnd, cyc[15:0]};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=kind%0d/round%0d/cyc%0d required=none",
                     kind, rnd, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL event actual=kind%0d/round%0d/cyc%0d required=kind%0d/round%0d/cyc%0d",
                         got[22:20], got[19:16], got[15:0], want[22:20], want[19:16], want[15:0]);
            end
        end
    endtask

    // Monitor: every visible DUT event is popped against the expected queue.
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            if (mem_wr === 1'b1 && mem_rd === 1'b1)
                check("wr_rd_exclusive", 32'(mem_wr & mem_rd), 32'd0);
            if (mem_wr === 1'b1) observe(K_WR, mem_round);
            if (mem_rd === 1'b1) observe(K_RD, mem_round);
            if (dec_key_valid === 1'b1 && dec_key_ready === 1'b1) observe(K_ACC, mem_round);
            if (dec_done === 1'b1) observe(K_DONE, 4'd0);
            if (cfg_err === 1'b1) observe(K_CFG, 4'd0);
        end
    end

    initial begin
        int c;
        int d;

        // Reset with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            keygen_start  = 1'($urandom_range(0, 1));
            key_size      = 2'($urandom_range(0, 3));
            rk_valid      = 1'($urandom_range(0, 1));
            dec_start     = 1'($urandom_range(0, 1));
            dec_key_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("reset_outputs", 32'({rk_ready, mem_wr, mem_rd, mem_round, dec_key_valid,
                                    keys_loaded, busy, dec_done, cfg_err}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        keygen_start = 1'b0; key_size = 2'd0; rk_valid = 1'b0;
        dec_start = 1'b0; dec_key_ready = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // dec_start in IDLE is ignored.
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        check("idle_dec_start_ignored", 32'(dbg_state), 32'(S_IDLE));
        tick();

        // AES-128 back-to-back load.
        c = cyc;
        keygen_start = 1'b1; key_size = 2'd0; rk_valid = 1'b1;
        for (int r = 0; r <= 10; r++) push(K_WR, r, c + 1 + r);
        tick();
        keygen_start = 1'b0;
        check("load128_rk_ready", 32'(rk_ready), 32'd1);
        check("load128_busy", 32'(busy), 32'd1);
        repeat (11) tick();
        check("load128_keys_loaded", 32'(keys_loaded), 32'd1);
        check("load128_ready_state", 32'(dbg_state), 32'(S_READY));
        rk_valid = 1'b0;

        // AES-128 decrypt, ready tied high.
        d = cyc;
        dec_start = 1'b1; dec_key_ready = 1'b1;
        for (int k = 10; k >= 0; k--) begin
            push(K_RD, k, d + 1 + 2 * (10 - k));
            push(K_ACC, k, d + 2 + 2 * (10 - k));
        end
        push(K_DONE, 0, d + 23);
        tick();
        dec_start = 1'b0;
        repeat (23) tick();
        check("dec128_done_width", 32'(dec_done), 32'd0);
        check("dec128_ready_state", 32'(dbg_state), 32'(S_READY));
        dec_key_ready = 1'b0;

        // AES-192 load with rk_valid bubbles, dec_start during LOAD ignored.
        c = cyc;
        keygen_start = 1'b1; key_size = 2'd1; rk_valid = 1'b0;
        for (int j = 0; j <= 12; j++) push(K_WR, j, c + 1 + 2 * j);
        tick();
        keygen_start = 1'b0;
        check("load192_keys_cleared", 32'(keys_loaded), 32'd0);
        for (int i = 0; i < 25; i++) begin
            rk_valid  = (i % 2 == 0);
            dec_start = (i == 3);
            tick();
        end
        rk_valid = 1'b0; dec_start = 1'b0;
        check("load192_keys_loaded", 32'(keys_loaded), 32'd1);
        check("load192_ready_state", 32'(dbg_state), 32'(S_READY));

        // AES-192 decrypt with a 5-cycle stall on key 12.
        d = cyc;
        dec_start = 1'b1; dec_key_ready = 1'b0;
        push(K_RD, 12, d + 1);
        push(K_ACC, 12, d + 7);
        for (int k = 11; k >= 0; k--) begin
            push(K_RD, k, d + 8 + 2 * (11 - k));
            push(K_ACC, k, d + 9 + 2 * (11 - k));
        end
        push(K_DONE, 0, d + 32);
        tick();
        dec_start = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'(dec_key_valid), 32'd1);
            check("stall_no_rd", 32'(mem_rd), 32'd0);
            check("stall_round", 32'(mem_round), 32'd12);
            tick();
        end
        dec_key_ready = 1'b1;
        repeat (26) tick();
        dec_key_ready = 1'b0;
        check("dec192_ready_state", 32'(dbg_state), 32'(S_READY));

        // keygen_start and dec_start together in READY: reload wins.
        c = cyc;
        keygen_start = 1'b1; dec_start = 1'b1; key_size = 2'd0; rk_valid = 1'b0;
        for (int r = 0; r <= 10; r++) push(K_WR, r, c + 1 + r);
        tick();
        keygen_start = 1'b0; dec_start = 1'b0;
        check("collide_state", 32'(dbg_state), 32'(S_LOAD));
        check("collide_keys_loaded", 32'(keys_loaded), 32'd0);
        check("collide_no_rd", 32'(mem_rd), 32'd0);
        rk_valid = 1'b1;
        repeat (11) tick();
        rk_valid = 1'b0;
        check("reload_keys_loaded", 32'(keys_loaded), 32'd1);

        // Reset while presenting key 5.
        d = cyc;
        dec_start = 1'b1; dec_key_ready = 1'b1;
        for (int k = 10; k >= 6; k--) begin
            push(K_RD, k, d + 1 + 2 * (10 - k));
            push(K_ACC, k, d + 2 + 2 * (10 - k));
        end
        push(K_RD, 5, d + 11);
        tick();
        dec_start = 1'b0;
        repeat (10) tick();
        dec_key_ready = 1'b0;
        tick();
        check("midreset_round", 32'(mem_round), 32'd5);
        check("midreset_present", 32'(dec_key_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_state", 32'(dbg_state), 32'(S_IDLE));
        check("midreset_keys_loaded", 32'(keys_loaded), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        check("postreset_no_rd", 32'(mem_rd), 32'd0);
        check("postreset_state", 32'(dbg_state), 32'(S_IDLE));
        tick();

        // Unsupported key sizes in IDLE.
        c = cyc;
        keygen_start = 1'b1; key_size = 2'd2; rk_valid = 1'b1;
        push(K_CFG, 0, c + 1);
        tick();
        keygen_start = 1'b0;
        check("cfg_err_state", 32'(dbg_state), 32'(S_IDLE));
        tick();
        check("cfg_err_width", 32'(cfg_err), 32'd0);
        c = cyc;
        keygen_start = 1'b1; key_size = 2'd3;
        push(K_CFG, 0, c + 1);
        tick();
        keygen_start = 1'b0; rk_valid = 1'b0;
        repeat (3) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
